// File: rtl/signed_digit_recompose_pkg.sv
// signed_digit_recompose_pkg: shared gadget parameters and recompose FSM encoding
package signed_digit_recompose_pkg;

   localparam int DATA_SIZE_ARB   = 14;
   localparam int MODULUS         = 12289;
   localparam int MODULUSHALF     = MODULUS / 2;
   localparam int GADGET_BASE_LOG = 7;
   localparam int GADGET_DIGITS   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/signed_digit_recompose_mod_add_q.sv
// mod_add_q: combinational (a + b) mod Q for a, b already in [0, Q)
module mod_add_q
   import signed_digit_recompose_pkg::*;
#(
   parameter int DATA_W  = DATA_SIZE_ARB,
   parameter int MODULUS = signed_digit_recompose_pkg::MODULUS
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y
);

   localparam logic [DATA_W:0] Q = (DATA_W+1)'(MODULUS);

   logic [DATA_W:0] s;

   // one extra bit holds the carry so a single conditional subtract suffices
   always_comb begin
      s = {1'b0, a} + {1'b0, b};
      y = DATA_W'(s >= Q ? s - Q : s);
   end

endmodule

// File: rtl/signed_digit_recompose.sv
// signed_digit_recompose: serial Horner rebuild of a signed base-2^BASE_LOG gadget word mod Q
module signed_digit_recompose
   import signed_digit_recompose_pkg::*;
#(
   parameter int DATA_W     = DATA_SIZE_ARB,
   parameter int MODULUS    = signed_digit_recompose_pkg::MODULUS,
   parameter int BASE_LOG   = GADGET_BASE_LOG,
   parameter int NUM_DIGITS = GADGET_DIGITS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_digit,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_value,
   output logic              out_err,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int CNT_W = $clog2(NUM_DIGITS + 1);
   localparam int SH_W  = $clog2(BASE_LOG + 1);
   localparam logic [DATA_W-1:0] Q    = DATA_W'(MODULUS);
   localparam logic [DATA_W-1:0] HALF = DATA_W'(1 << (BASE_LOG - 1));

   state_t            state, state_n;
   logic [DATA_W-1:0] acc, acc_n, digit, add_b, sum;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [SH_W-1:0]   sh, sh_n;
   logic              err, err_n, illegal, in_hs, out_hs;

   assign in_ready  = state == IDLE || state == WAIT;
   assign out_valid = state == DONE;
   assign out_value = out_valid ? acc : '0;
   assign out_err   = out_valid & err;
   assign in_hs     = in_valid & in_ready;
   assign out_hs    = out_valid & out_ready;

   // legal digits are small positives or small negatives encoded near Q; anything
   // at or above Q is folded back once so acc stays inside [0, Q)
   assign illegal = !(in_digit < HALF || in_digit >= Q - HALF);
   assign digit   = in_digit >= Q ? in_digit - Q : in_digit;

   // the single adder doubles acc while shifting and adds the new digit otherwise
   assign add_b = state == SHIFT ? acc : digit;

   mod_add_q #(.DATA_W(DATA_W), .MODULUS(MODULUS)) u_add (
      .a(acc),
      .b(add_b),
      .y(sum)
   );

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         sh    <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         cnt   <= cnt_n;
         sh    <= sh_n;
         err   <= err_n;
      end
   end

   // Horner sequencing: load MSB digit, BASE_LOG doublings, add next digit, repeat
   always_comb begin
      state_n = state;
      acc_n   = acc;
      cnt_n   = cnt;
      sh_n    = sh;
      err_n   = err;
      case (state)
         IDLE: if (in_hs) begin
            acc_n   = digit;
            err_n   = illegal;
            cnt_n   = CNT_W'(NUM_DIGITS - 1);
            sh_n    = '0;
            state_n = NUM_DIGITS == 1 ? DONE : SHIFT;
         end
         SHIFT: begin
            acc_n   = sum;
            sh_n    = sh == SH_W'(BASE_LOG - 1) ? '0 : sh + 1'b1;
            state_n = sh == SH_W'(BASE_LOG - 1) ? WAIT : SHIFT;
         end
         WAIT: if (in_hs) begin
            acc_n   = sum;
            err_n   = err | illegal;
            cnt_n   = cnt - 1'b1;
            sh_n    = '0;
            state_n = cnt == CNT_W'(1) ? DONE : SHIFT;
         end
         DONE: if (out_hs) begin
            acc_n   = '0;
            err_n   = 1'b0;
            state_n = IDLE;
         end
      endcase
   end

endmodule
